// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared MD opcode encoding, default latencies and sequencer states
package md_unit_pkg;

    // Must stay aligned with the hazard unit's start/busy stall decode.
    localparam logic [3:0] MD_NONE  = 4'b0000;
    localparam logic [3:0] MD_MULT  = 4'b0001;
    localparam logic [3:0] MD_MULTU = 4'b0010;
    localparam logic [3:0] MD_DIV   = 4'b0011;
    localparam logic [3:0] MD_DIVU  = 4'b0100;
    localparam logic [3:0] MD_MFHI  = 4'b0101;
    localparam logic [3:0] MD_MFLO  = 4'b0110;
    localparam logic [3:0] MD_MTHI  = 4'b0111;
    localparam logic [3:0] MD_MTLO  = 4'b1000;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    function automatic logic md_is_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational {hi,lo} result for MULT/MULTU/DIV/DIVU
module md_calc
    import md_unit_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_res
);

    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;

    assign w_sa    = i_a;
    assign w_sb    = i_b;
    assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

    always_comb begin
        o_res = 64'd0;
        case (i_op)
            MD_MULT:  o_res = w_sprod;
            MD_MULTU: o_res = w_uprod;
            MD_DIV: begin
                // Zero divisor and the single overflowing signed case are fixed results.
                if (i_b == 32'd0)
                    o_res = {i_a, 32'hFFFF_FFFF};
                else if (i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF)
                    o_res = {32'd0, 32'h8000_0000};
                else
                    o_res = {32'(w_sa % w_sb), 32'(w_sa / w_sb)};
            end
            MD_DIVU: begin
                if (i_b == 32'd0)
                    o_res = {i_a, 32'hFFFF_FFFF};
                else
                    o_res = {i_a % i_b, i_a / i_b};
            end
            default: o_res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide sequencer owning HI/LO
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

    md_state_t   r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic [63:0] w_res;

    md_calc u_calc (
        .i_op  (op),
        .i_a   (a),
        .i_b   (b),
        .o_res (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (md_is_start(op)) begin
                        r_pend_hi <= w_res[63:32];
                        r_pend_lo <= w_res[31:0];
                        r_cnt     <= (op == MD_MULT || op == MD_MULTU) ? LP_MULT_N : LP_DIV_N;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end else if (op == MD_MTHI) begin
                        r_hi <= a;
                    end else if (op == MD_MTLO) begin
                        r_lo <= a;
                    end
                end
                ST_RUN: begin
                    // Every non-read op is dropped here so a stray issue cannot corrupt HI/LO.
                    if (r_cnt == 4'd1) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        md_out = 32'd0;
        if (op == MD_MFHI)
            md_out = r_hi;
        else if (op == MD_MFLO)
            md_out = r_lo;
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed scoreboard bench for md_unit
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  op = MD_NONE;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a start op, optionally intrude with ops in RUN cycles 2..4, then check commit.
    task automatic run_op(input string tag, input logic [3:0] opc, input logic [31:0] ia,
                          input logic [31:0] ib, input int n, input logic [63:0] exp64,
                          input logic [3:0] i2, input logic [3:0] i3, input logic [3:0] i4);
        logic [63:0] got;
        op = opc; a = ia; b = ib;
        sb_q.push_back(exp64);
        #1;
        check({tag, " busy@T"}, {31'd0, busy}, 32'd0);
        tick;
        for (int k = 1; k <= n; k++) begin
            op = (k == 2) ? i2 : (k == 3) ? i3 : (k == 4) ? i4 : MD_NONE;
            a = 32'hDEAD_BEEF; b = 32'd1;
            #1;
            check($sformatf("%s busy@T+%0d", tag, k), {31'd0, busy}, 32'd1);
            if (op == MD_MFHI) check({tag, " mfhi_in_run"}, md_out, m_hi);
            if (k == n) begin
                check({tag, " hi_held"}, hi, m_hi);
                check({tag, " lo_held"}, lo, m_lo);
            end
            tick;
        end
        op = MD_NONE;
        check({tag, " busy@T+N+1"}, {31'd0, busy}, 32'd0);
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            m_hi = got[63:32];
            m_lo = got[31:0];
            check({tag, " hi"}, hi, m_hi);
            check({tag, " lo"}, lo, m_lo);
        end
    endtask

    initial begin
        tick;
        tick;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst md_out", md_out, 32'd0);
        rst_n = 1'b1;
        tick;

        op = MD_MTHI; a = 32'h0000_1234;
        tick;
        m_hi = 32'h0000_1234;
        op = MD_MFHI;
        #1;
        check("mthi->mfhi", md_out, 32'h0000_1234);
        op = MD_MTLO; a = 32'h0000_5678;
        tick;
        m_lo = 32'h0000_5678;
        op = MD_MFLO;
        #1;
        check("mtlo->mflo", md_out, 32'h0000_5678);
        check("mtlo hi kept", hi, 32'h0000_1234);
        op = MD_NONE;
        tick;

        run_op("mult_intr", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5,
               {32'hFFFF_FFFF, 32'hFFFF_FFFA}, MD_MFHI, MD_MTLO, MD_DIVU);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5,
               {32'h0000_0002, 32'hFFFF_FFFA}, MD_NONE, MD_NONE, MD_NONE);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, MD_MFHI, MD_MTHI, MD_NONE);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 10,
               {32'd1, 32'd3}, MD_NONE, MD_NONE, MD_NONE);
        run_op("div0", MD_DIV, 32'd5, 32'd0, 10,
               {32'd5, 32'hFFFF_FFFF}, MD_NONE, MD_NONE, MD_NONE);
        run_op("divu0", MD_DIVU, 32'h8000_0001, 32'd0, 10,
               {32'h8000_0001, 32'hFFFF_FFFF}, MD_NONE, MD_NONE, MD_NONE);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               {32'd0, 32'h8000_0000}, MD_NONE, MD_NONE, MD_NONE);

        op = MD_DIV; a = 32'd100; b = 32'd7;
        sb_q.push_back({32'd2, 32'd14});
        tick;
        op = MD_NONE;
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst busy", {31'd0, busy}, 32'd0);
        check("midrun_rst hi", hi, 32'd0);
        check("midrun_rst lo", lo, 32'd0);
        void'(sb_q.pop_back());
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1;
        rst_n = 1'b1;
        tick;
        check("post_rst busy", {31'd0, busy}, 32'd0);

        run_op("mult_after_rst", MD_MULT, 32'd6, 32'hFFFF_FFFD, 5,
               {32'hFFFF_FFFF, 32'hFFFF_FFEE}, MD_NONE, MD_NONE, MD_NONE);

        op = MD_DIV; a = 32'd9; b = 32'd4;
        sb_q.push_back({32'd1, 32'd2});
        tick;
        op = MD_NONE;
        check("b2b busy", {31'd0, busy}, 32'd1);
        repeat (10) tick;
        check("b2b hi", hi, 32'd1);
        check("b2b lo", lo, 32'd2);
        void'(sb_q.pop_front());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
